immgen_pipe: RTL

- Registered, parametrised successor to the combinational immediate generator.
- Decodes the immediate and its format class from a fetched instruction and carries a caller tag (PC / ROB id) alongside.
- Buffers results in a small output queue with valid/ready handshakes on both sides, so decode can sit between fetch and the ID/EX register under backpressure.
- Supports XLEN 32/64, all RV base formats, and full-width shift amounts; RVC immediates are optional.

---
 rtl/immgen_pkg.sv | 34 +++
 rtl/immgen_if.sv | 33 +++
 rtl/immgen_core.sv | 169 ++++++++++++++++
 rtl/immgen_pipe.sv | 109 ++++++++++
 4 files changed

// File: rtl/immgen_pkg.sv
// immgen_pkg: format classes, base opcodes and shift-amount width helper
// shared by the immediate generator core, its pipeline wrapper and its bus.
package immgen_pkg;

  // Format class reported alongside each decoded immediate.
  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // Shift-amount field width for a given datapath width.
  function automatic int shamt_w(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/immgen_if.sv
// immgen_if: upstream (instruction/tag) and downstream (immediate/format/tag)
// valid/ready handshakes plus the redirect flush for immgen_pipe.
interface immgen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  import immgen_pkg::*;

  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      inst_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  imm_o;
  fmt_e             fmt_o;
  logic             is_rvc_o;
  logic [TAG_W-1:0] tag_o;

  // Environment side: fetch producer and ID/EX consumer.
  modport master (
    output flush_i, in_valid_i, inst_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, fmt_o, is_rvc_o, tag_o
  );

  // Decoder side.
  modport slave (
    input  flush_i, in_valid_i, inst_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, fmt_o, is_rvc_o, tag_o
  );

endinterface

// File: rtl/immgen_core.sv
// immgen_core: combinational instruction -> {immediate, format, is_rvc}.
// Compressed decoding is compiled in when IMMGEN_RVC_EN is defined; otherwise
// any 16-bit encoding is reported as ILLEGAL.
module immgen_core
  import immgen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            is_rvc
);

  localparam int SW = shamt_w(XLEN);

  // Every immediate fits in 32 bits with its final sign already in bit 31,
  // so widening to XLEN is a single sign extension at the end.
  logic [31:0] imm32;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Decode format and raw 32-bit immediate.
  always_comb begin
    imm32  = '0;
    fmt    = FMT_ILLEGAL;
    is_rvc = 1'b0;
    if (inst[1:0] == 2'b11) begin
      case (opcode)
        OPC_OP_IMM: begin
          if (is_shift) begin
            fmt   = FMT_SHAMT;
            imm32 = 32'(inst[20 +: SW]);
          end else begin
            fmt   = FMT_I;
            imm32 = {{20{inst[31]}}, inst[31:20]};
          end
        end
        OPC_OP_IMM32: begin
          if (XLEN == 64) begin
            if (is_shift) begin
              fmt   = FMT_SHAMT;
              imm32 = {27'b0, inst[24:20]};
            end else begin
              fmt   = FMT_I;
              imm32 = {{20{inst[31]}}, inst[31:20]};
            end
          end
        end
        OPC_LOAD, OPC_JALR: begin
          fmt   = FMT_I;
          imm32 = {{20{inst[31]}}, inst[31:20]};
        end
        OPC_STORE: begin
          fmt   = FMT_S;
          imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
        OPC_BRANCH: begin
          fmt   = FMT_B;
          imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt   = FMT_U;
          imm32 = {inst[31:12], 12'b0};
        end
        OPC_JAL: begin
          fmt   = FMT_J;
          imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        OPC_OP, OPC_OP32: begin
          fmt   = FMT_R;
        end
        default: ;
      endcase
    end
`ifdef IMMGEN_RVC_EN
    else begin
      is_rvc = 1'b1;
      case (inst[1:0])
        2'b00: begin
          case (inst[15:13])
            3'b000: begin  // C.ADDI4SPN, zero immediate is reserved
              imm32 = {22'b0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b00};
              fmt   = (imm32 == '0) ? FMT_ILLEGAL : FMT_I;
            end
            3'b010: begin  // C.LW
              imm32 = {25'b0, inst[5], inst[12:10], inst[6], 2'b00};
              fmt   = FMT_I;
            end
            3'b110: begin  // C.SW
              imm32 = {25'b0, inst[5], inst[12:10], inst[6], 2'b00};
              fmt   = FMT_S;
            end
            default: ;
          endcase
        end
        2'b01: begin
          case (inst[15:13])
            3'b000, 3'b010: begin  // C.ADDI, C.LI
              imm32 = {{26{inst[12]}}, inst[12], inst[6:2]};
              fmt   = FMT_I;
            end
            3'b001: begin  // C.JAL exists only on RV32 (C.ADDIW otherwise)
              if (XLEN == 32) begin
                imm32 = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6],
                         inst[7], inst[2], inst[11], inst[5:3], 1'b0};
                fmt   = FMT_J;
              end
            end
            3'b011: begin
              if (inst[11:7] == 5'd2) begin  // C.ADDI16SP
                imm32 = {{22{inst[12]}}, inst[12], inst[4:3], inst[5], inst[2],
                         inst[6], 4'b0};
                fmt   = (imm32 == '0) ? FMT_ILLEGAL : FMT_I;
              end else begin  // C.LUI
                imm32 = {{14{inst[12]}}, inst[12], inst[6:2], 12'b0};
                fmt   = (imm32 == '0) ? FMT_ILLEGAL : FMT_U;
              end
            end
            3'b100: begin  // C.SRLI / C.SRAI; shamt[5] is reserved on RV32
              if (!inst[11] && (XLEN == 64 || !inst[12])) begin
                imm32 = {26'b0, inst[12], inst[6:2]};
                fmt   = FMT_SHAMT;
              end
            end
            3'b101: begin  // C.J
              imm32 = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6],
                       inst[7], inst[2], inst[11], inst[5:3], 1'b0};
              fmt   = FMT_J;
            end
            default: begin  // C.BEQZ, C.BNEZ
              imm32 = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10],
                       inst[4:3], 1'b0};
              fmt   = FMT_B;
            end
          endcase
        end
        default: begin
          case (inst[15:13])
            3'b000: begin  // C.SLLI
              if (XLEN == 64 || !inst[12]) begin
                imm32 = {26'b0, inst[12], inst[6:2]};
                fmt   = FMT_SHAMT;
              end
            end
            3'b010: begin  // C.LWSP
              imm32 = {24'b0, inst[3:2], inst[12], inst[6:4], 2'b00};
              fmt   = FMT_I;
            end
            3'b110: begin  // C.SWSP
              imm32 = {24'b0, inst[8:7], inst[12:9], 2'b00};
              fmt   = FMT_S;
            end
            default: ;
          endcase
        end
      endcase
    end
`endif
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/immgen_pipe.sv
// immgen_pipe: registered immediate generator. Decodes on push and buffers
// {imm, fmt, is_rvc, tag} in a DEPTH-entry FIFO with valid/ready on both sides.
// Optional compressed decoding: define IMMGEN_RVC_EN.
module immgen_pipe
  import immgen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  immgen_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             is_rvc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] core_imm;
  fmt_e            core_fmt;
  logic            core_rvc;
  entry_t          wr_entry;
  entry_t          head;
  entry_t          slot [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW:0]   count_reg, count_next;
  logic          full, push, pop;

  immgen_core #(.XLEN(XLEN)) u_core (
    .inst   (bus.inst_i),
    .imm    (core_imm),
    .fmt    (core_fmt),
    .is_rvc (core_rvc)
  );

  assign wr_entry = '{imm: core_imm, fmt: core_fmt, is_rvc: core_rvc, tag: bus.tag_i};

  // Handshake qualifiers come only from registered count, so in_ready has
  // no path from out_ready.
  assign full = (count_reg == (PW+1)'(DEPTH));
  assign push = bus.in_valid_i & ~full;
  assign pop  = (count_reg != '0) & bus.out_ready_i;

  // Pointer/count update; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (bus.flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      wr_ptr_next = wr_ptr_reg + PW'(push);
      rd_ptr_next = rd_ptr_reg + PW'(pop);
      count_next  = count_reg + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Queue bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // One register per queue entry, written when it is the push target.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    entry_t entry_reg;

    // Capture the decoded instruction into this entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_reg <= '0;
      end else if (push && !bus.flush_i && (wr_ptr_reg == PW'(gi))) begin
        entry_reg <= wr_entry;
      end
    end

    assign slot[gi] = entry_reg;
  end

  // Head entry presented to the consumer.
  always_comb begin
    head = slot[rd_ptr_reg];
  end

  assign bus.in_ready_o  = ~full;
  assign bus.out_valid_o = (count_reg != '0);
  assign bus.imm_o       = head.imm;
  assign bus.fmt_o       = head.fmt;
  assign bus.is_rvc_o    = head.is_rvc;
  assign bus.tag_o       = head.tag;

endmodule
